ssd_scan_driver: RTL and testbench

- Parametrised successor to the fixed four-digit seven-segment driver.
- Single clock domain; the refresh rate comes from an internal prescaler, so no separate display clock is needed.
- Accepts a raw binary value from the CPU and converts it to BCD sequentially using double-dabble.
- Supports signed display, leading-zero blanking and overflow indication. Scans NUM_DIGITS common-anode digits.

---
 rtl/ssd_pkg.sv | 57 +++++
 rtl/bin2bcd_seq.sv | 98 +++++++++
 rtl/ssd_scan_driver.sv | 147 ++++++++++++++
 tb/tb_ssd_scan_driver.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// Shared digit codes, segment patterns, FSM encoding and segment decoder for the scan driver.
package ssd_pkg;

    // 4-bit digit codes held in the display registers
    localparam logic [3:0] CODE_0     = 4'h0;
    localparam logic [3:0] CODE_1     = 4'h1;
    localparam logic [3:0] CODE_2     = 4'h2;
    localparam logic [3:0] CODE_3     = 4'h3;
    localparam logic [3:0] CODE_4     = 4'h4;
    localparam logic [3:0] CODE_5     = 4'h5;
    localparam logic [3:0] CODE_6     = 4'h6;
    localparam logic [3:0] CODE_7     = 4'h7;
    localparam logic [3:0] CODE_8     = 4'h8;
    localparam logic [3:0] CODE_9     = 4'h9;
    localparam logic [3:0] CODE_MINUS = 4'hA;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    // Active-low segment patterns {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [0:0] {
        StIdle,
        StConv
    } conv_state_e;

    // Unknown codes render blank rather than garbage
    function automatic logic [6:0] code_to_seg(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            CODE_0:     seg = SEG_0;
            CODE_1:     seg = SEG_1;
            CODE_2:     seg = SEG_2;
            CODE_3:     seg = SEG_3;
            CODE_4:     seg = SEG_4;
            CODE_5:     seg = SEG_5;
            CODE_6:     seg = SEG_6;
            CODE_7:     seg = SEG_7;
            CODE_8:     seg = SEG_8;
            CODE_9:     seg = SEG_9;
            CODE_MINUS: seg = SEG_MINUS;
            default:    seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift iteration per clock, VALUE_W iterations.
// done_o is high in the cycle whose closing edge completes the conversion; bcd_o and neg_o
// carry the finished result for that edge so the consumer can commit on the same edge.
module bin2bcd_seq
    import ssd_pkg::*;
#(
    parameter int unsigned VALUE_W   = 13,
    parameter int unsigned DD_DIGITS = (VALUE_W + 2) / 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [VALUE_W-1:0]     value_i,
    input  logic                   signed_mode_i,
    input  logic                   load_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [4*DD_DIGITS-1:0] bcd_o,
    output logic                   neg_o
);

    localparam int unsigned CntW = $clog2(VALUE_W + 1);

    conv_state_e              state_q, state_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [VALUE_W-1:0]       mag_q, mag_d;
    logic [4*DD_DIGITS-1:0]   bcd_q, bcd_d;
    logic                     neg_q, neg_d;
    logic [4*DD_DIGITS-1:0]   bcd_adj;
    logic [4*DD_DIGITS-1:0]   bcd_shift;

    // One double-dabble step: add 3 to every nibble >= 5, then shift in the magnitude MSB
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(DD_DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        bcd_shift = {bcd_adj[4*DD_DIGITS-2:0], mag_q[VALUE_W-1]};
    end

    // Conversion FSM next-state: capture on load in idle, iterate in conv
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mag_d   = mag_q;
        bcd_d   = bcd_q;
        neg_d   = neg_q;
        unique case (state_q)
            StIdle: begin
                if (load_i) begin
                    if (signed_mode_i && value_i[VALUE_W-1]) begin
                        mag_d = -value_i;
                        neg_d = 1'b1;
                    end else begin
                        mag_d = value_i;
                        neg_d = 1'b0;
                    end
                    bcd_d   = '0;
                    cnt_d   = CntW'(VALUE_W);
                    state_d = StConv;
                end
            end
            StConv: begin
                bcd_d = bcd_shift;
                mag_d = mag_q << 1;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CntW'(1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State register; reset aborts any conversion in flight
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mag_q   <= '0;
            bcd_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mag_q   <= mag_d;
            bcd_q   <= bcd_d;
            neg_q   <= neg_d;
        end
    end

    assign busy_o = (state_q == StConv);
    assign done_o = (state_q == StConv) && (cnt_q == CntW'(1));
    assign bcd_o  = bcd_shift;
    assign neg_o  = neg_q;

endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment driver: sequential BCD conversion, sign/overflow/blanking
// resolution at commit, and a prescaled scanner with registered anode/segment outputs.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int unsigned NUM_DIGITS  = 4,
    parameter int unsigned VALUE_W     = 13,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [VALUE_W-1:0]    value,
    input  logic                  signed_mode,
    input  logic                  blank_lz,
    input  logic                  load,
    output logic                  busy,
    output logic [NUM_DIGITS-1:0] anode,
    output logic [6:0]            seg
);

    localparam int unsigned DD_DIGITS  = (VALUE_W + 2) / 3;
    // Converter may produce fewer digits than are displayed; pad with zeros
    localparam int unsigned AllDigits  = (NUM_DIGITS > DD_DIGITS) ? NUM_DIGITS : DD_DIGITS;
    localparam int unsigned PrescW     = $clog2(REFRESH_DIV);
    localparam int unsigned IdxW       = $clog2(NUM_DIGITS);

    logic                   conv_busy;
    logic                   conv_done;
    logic [4*DD_DIGITS-1:0] conv_bcd;
    logic                   conv_neg;

    bin2bcd_seq #(
        .VALUE_W   (VALUE_W),
        .DD_DIGITS (DD_DIGITS)
    ) u_bin2bcd (
        .clk_i         (clk),
        .rst_i         (rst),
        .value_i       (value),
        .signed_mode_i (signed_mode),
        .load_i        (load),
        .busy_o        (conv_busy),
        .done_o        (conv_done),
        .bcd_o         (conv_bcd),
        .neg_o         (conv_neg)
    );

    assign busy = conv_busy;

    logic                  blank_q;
    logic [3:0]            code_q   [NUM_DIGITS];
    logic [3:0]            code_new [NUM_DIGITS];
    logic [3:0]            dig      [AllDigits];
    logic                  ovf;
    int                    msd;
    int                    minus_pos;

    logic [PrescW-1:0]     presc_q, presc_d;
    logic [IdxW-1:0]       idx_q, idx_d, idx_nxt;
    logic                  active_q, active_d;
    logic [NUM_DIGITS-1:0] anode_d;
    logic [6:0]            seg_d;

    // Resolve overflow, leading-zero blanking and sign placement for the result being committed
    always_comb begin
        for (int i = 0; i < int'(AllDigits); i++) begin
            dig[i] = (i < int'(DD_DIGITS)) ? conv_bcd[4*i +: 4] : 4'd0;
        end
        ovf = 1'b0;
        for (int i = int'(NUM_DIGITS); i < int'(AllDigits); i++) begin
            if (dig[i] != 4'd0) ovf = 1'b1;
        end
        if (conv_neg && dig[NUM_DIGITS-1] != 4'd0) ovf = 1'b1;
        msd = 0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (dig[i] != 4'd0) msd = i;
        end
        minus_pos = blank_q ? msd + 1 : int'(NUM_DIGITS) - 1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (ovf) begin
                code_new[i] = CODE_MINUS;
            end else if (conv_neg && i == minus_pos) begin
                code_new[i] = CODE_MINUS;
            end else if (blank_q && i > msd) begin
                code_new[i] = CODE_BLANK;
            end else begin
                code_new[i] = dig[i];
            end
        end
    end

    // Display registers: blanking mode follows load, digit codes change only at commit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blank_q <= 1'b0;
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                code_q[i] <= (i == 0) ? CODE_0 : CODE_BLANK;
            end
        end else begin
            if (load && !conv_busy) blank_q <= blank_lz;
            if (conv_done) begin
                for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                    code_q[i] <= code_new[i];
                end
            end
        end
    end

    // Scanner next-state: anode and seg move together on prescaler wrap; seg also
    // refreshes every cycle so a commit shows up within the current dwell
    always_comb begin
        presc_d  = presc_q + 1'b1;
        idx_d    = idx_q;
        active_d = active_q;
        anode_d  = anode;
        seg_d    = active_q ? code_to_seg(code_q[idx_q]) : SEG_BLANK;
        if (!active_q || idx_q == IdxW'(NUM_DIGITS - 1)) begin
            idx_nxt = '0;
        end else begin
            idx_nxt = idx_q + 1'b1;
        end
        if (presc_q == PrescW'(REFRESH_DIV - 1)) begin
            presc_d  = '0;
            idx_d    = idx_nxt;
            active_d = 1'b1;
            anode_d  = ~(NUM_DIGITS'(1) << idx_nxt);
            seg_d    = code_to_seg(code_q[idx_nxt]);
        end
    end

    // Scanner and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q  <= '0;
            idx_q    <= '0;
            active_q <= 1'b0;
            anode    <= '1;
            seg      <= SEG_BLANK;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            active_q <= active_d;
            anode    <= anode_d;
            seg      <= seg_d;
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench: stimulus pushes the expected display for every load it expects to be
// accepted; a negedge monitor predicts the scan and pops the expectation at each commit.
module tb_ssd_scan_driver;

    localparam int unsigned N   = 4;
    localparam int unsigned W   = 13;
    localparam int unsigned DIV = 4;

    typedef logic [N-1:0][6:0] segs_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] value = '0;
    logic         signed_mode = 1'b0;
    logic         blank_lz = 1'b0;
    logic         load = 1'b0;
    logic         busy;
    logic [N-1:0] anode;
    logic [6:0]   seg;

    ssd_scan_driver #(
        .NUM_DIGITS  (N),
        .VALUE_W     (W),
        .REFRESH_DIV (DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .value       (value),
        .signed_mode (signed_mode),
        .blank_lz    (blank_lz),
        .load        (load),
        .busy        (busy),
        .anode       (anode),
        .seg         (seg)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int edge_cnt;
    int last_acc   = -1000;
    segs_t sb_q [$];
    logic [6:0] digit_seg [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                   7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // Clock edges since reset release, counted the same way the DUT sees them
    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic segs_t reset_disp();
        segs_t r = {N{7'h7F}};
        r[0] = 7'h40;
        return r;
    endfunction

    // Reference: decimal digits by division, then overflow / blank / sign rules
    function automatic segs_t ref_segs(input logic [W-1:0] v, input logic sm, input logic bl);
        int unsigned mag, tmp;
        bit          neg, ovf;
        int          d [N];
        int          top;
        segs_t       r;
        neg = sm && v[W-1];
        mag = neg ? ((32'd1 << W) - 32'(v)) : 32'(v);
        ovf = (mag >= 10 ** N) || (neg && mag >= 10 ** (N - 1));
        tmp = mag;
        top = 0;
        for (int i = 0; i < int'(N); i++) begin
            d[i] = int'(tmp % 10);
            tmp  = tmp / 10;
            if (d[i] != 0) top = i;
        end
        for (int i = 0; i < int'(N); i++) begin
            if (ovf)                              r[i] = 7'h3F;
            else if (bl && neg && i == top + 1)   r[i] = 7'h3F;
            else if (bl && i > top)               r[i] = 7'h7F;
            else if (!bl && neg && i == N - 1)    r[i] = 7'h3F;
            else                                  r[i] = digit_seg[d[i]];
        end
        return r;
    endfunction

    // Issue a one-cycle load sampled gap+1 edges from now; expect acceptance only when idle
    task automatic issue(input int gap, input logic [W-1:0] v, input logic sm, input logic bl);
        int e;
        repeat (gap) @(posedge clk);
        #2;
        value = v; signed_mode = sm; blank_lz = bl; load = 1'b1;
        e = edge_cnt + 1;
        if (e > last_acc + int'(W)) begin
            last_acc = e;
            sb_q.push_back(ref_segs(v, sm, bl));
        end
        @(posedge clk);
        #2;
        load = 1'b0;
        value = W'($urandom); signed_mode = 1'($urandom); blank_lz = 1'($urandom);
    endtask

    task automatic settle();
        repeat (W + 2 * N * DIV + 4) @(posedge clk);
    endtask

    // Monitor: predicted scan position, displayed digits, busy length and commits
    initial begin
        segs_t      exp_disp;
        int         busy_run;
        logic       busy_prev;
        int         d;
        logic [N-1:0] ea;
        exp_disp  = reset_disp();
        busy_run  = 0;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_disp  = reset_disp();
                busy_run  = 0;
                busy_prev = 1'b0;
            end else begin
                if (edge_cnt < int'(DIV)) begin
                    check("anode_pre_scan", 32'(anode), 32'(N'('1)));
                    check("seg_pre_scan", 32'(seg), 32'h7F);
                end else begin
                    d  = ((edge_cnt / int'(DIV)) - 1) % int'(N);
                    ea = '1;
                    ea[d] = 1'b0;
                    check("anode_scan", 32'(anode), 32'(ea));
                    check("seg_digit", 32'(seg), 32'(exp_disp[d]));
                end
                if (busy) begin
                    busy_run++;
                end else if (busy_prev) begin
                    check("busy_len", 32'(busy_run), 32'(W));
                    if (sb_q.size() == 0) check("unexpected_commit", 32'd1, 32'd0);
                    else exp_disp = sb_q.pop_front();
                    busy_run = 0;
                end
                busy_prev = busy;
            end
        end
    end

    // Stimulus
    initial begin
        logic [W-1:0] v;
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_anode", 32'(anode), 32'(N'('1)));
        check("rst_seg", 32'(seg), 32'h7F);
        rst = 1'b0;
        settle();

        // Directed cases
        issue(2, W'(1234), 1'b0, 1'b0);   settle();
        issue(2, W'('h1FFB), 1'b1, 1'b1); settle();
        issue(2, W'('h1000), 1'b1, 1'b0); settle();
        issue(2, W'(9999), 1'b0, 1'b1);   settle();
        issue(2, W'(8191), 1'b0, 1'b0);   settle();
        v = W'(-999);
        issue(2, v, 1'b1, 1'b1);          settle();
        issue(2, v, 1'b1, 1'b0);          settle();
        v = W'(-1000);
        issue(2, v, 1'b1, 1'b1);          settle();
        issue(2, W'(0), 1'b0, 1'b1);      settle();
        issue(2, W'(7), 1'b0, 1'b0);      settle();

        // Loads during busy and on the finishing edge are dropped
        issue(2, W'(1234), 1'b0, 1'b1);
        issue(4, W'(5678), 1'b0, 1'b0);
        settle();
        issue(2, W'(42), 1'b0, 1'b1);
        issue(12, W'(77), 1'b0, 1'b0);
        settle();

        // Reset six cycles into a conversion
        issue(2, W'(4321), 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_anode", 32'(anode), 32'(N'('1)));
        sb_q.delete();
        last_acc = -1000;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        settle();

        // Randomised traffic, including back-to-back loads that must be ignored
        for (int t = 0; t < 40; t++) begin
            v = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 150)) : W'($urandom);
            issue(int'($urandom_range(1, 20)), v, 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 3) == 0) settle();
        end
        settle();

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        check("end_busy", 32'(busy), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
